// File: rtl/rggen_bit_field_access_driver.sv
`default_nettype none
// ============================================================================
// Module   : rggen_bit_field_access_driver
// Brief    : Turns one host register request into one bit-field access and
//            returns a single response with status (OKAY/SLVERR/TIMEOUT).
// Revision : 1.0 - initial release
// ============================================================================
module rggen_bit_field_access_driver #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
    input  logic [DATA_WIDTH-1:0]     i_req_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_req_strobe,
    output logic                      o_field_valid,
    output logic                      o_field_write,
    output logic [ADDRESS_WIDTH-1:0]  o_field_address,
    output logic [DATA_WIDTH-1:0]     o_field_write_data,
    output logic [DATA_WIDTH-1:0]     o_field_write_mask,
    input  logic                      i_field_ready,
    input  logic                      i_field_error,
    input  logic [DATA_WIDTH-1:0]     i_field_read_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [1:0]                o_rsp_status,
    output logic [DATA_WIDTH-1:0]     o_rsp_read_data
);

    localparam int C_STRB_W = DATA_WIDTH / 8;
    localparam int C_CNT_W  = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = {C_CNT_W{1'b1}};
    localparam logic [1:0] C_STS_OKAY    = 2'b00;
    localparam logic [1:0] C_STS_SLVERR  = 2'b10;
    localparam logic [1:0] C_STS_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_RESPONSE = 2'd2
    } state_e;

    state_e                     r_state;
    state_e                     w_state_next;
    logic                       r_req_ready;
    logic                       r_field_valid;
    logic                       r_rsp_valid;
    logic                       r_field_write;
    logic [ADDRESS_WIDTH-1:0]   r_field_address;
    logic [DATA_WIDTH-1:0]      r_field_write_data;
    logic [DATA_WIDTH-1:0]      r_field_write_mask;
    logic [1:0]                 r_rsp_status;
    logic [DATA_WIDTH-1:0]      r_rsp_read_data;
    logic [C_CNT_W-1:0]         r_count;
    logic                       w_accept;
    logic                       w_complete;
    logic                       w_timeout;
    logic [DATA_WIDTH-1:0]      w_strobe_mask;

    // Byte strobes widened to a per-bit mask
    for (genvar g = 0; g < C_STRB_W; g++) begin : g_mask
        assign w_strobe_mask[8*g +: 8] = {8{i_req_strobe[g]}};
    end

    if (TIMEOUT > 0) begin : g_timeout_en
        assign w_timeout = (r_state == ST_ACCESS) && !i_field_ready && (r_count == C_CNT_LAST);
    end else begin : g_timeout_dis
        assign w_timeout = 1'b0;
    end

    assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
    assign w_complete = (r_state == ST_ACCESS) && i_field_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_state_next = ST_ACCESS;
            ST_ACCESS:   if (w_complete || w_timeout) w_state_next = ST_RESPONSE;
            ST_RESPONSE: if (i_rsp_ready) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so every output is a flop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_field_valid <= 1'b0;
            r_rsp_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_req_ready   <= (w_state_next == ST_IDLE);
            r_field_valid <= (w_state_next == ST_ACCESS);
            r_rsp_valid   <= (w_state_next == ST_RESPONSE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_field_write      <= 1'b0;
            r_field_address    <= '0;
            r_field_write_data <= '0;
            r_field_write_mask <= '0;
            r_rsp_status       <= C_STS_OKAY;
            r_rsp_read_data    <= '0;
            r_count            <= '0;
        end else if (w_accept) begin
            r_field_write      <= i_req_write;
            r_field_address    <= i_req_address;
            r_field_write_data <= i_req_write ? i_req_write_data : '0;
            r_field_write_mask <= i_req_write ? w_strobe_mask : '0;
            r_count            <= '0;
        end else if (w_complete) begin
            r_rsp_status    <= i_field_error ? C_STS_SLVERR : C_STS_OKAY;
            r_rsp_read_data <= r_field_write ? '0 : i_field_read_data;
        end else if (w_timeout) begin
            r_rsp_status    <= C_STS_TIMEOUT;
            r_rsp_read_data <= '0;
        end else if ((r_state == ST_ACCESS) && (r_count != C_CNT_MAX)) begin
            r_count <= r_count + C_CNT_W'(1);
        end
    end

    assign o_req_ready        = r_req_ready;
    assign o_field_valid      = r_field_valid;
    assign o_field_write      = r_field_write;
    assign o_field_address    = r_field_address;
    assign o_field_write_data = r_field_write_data;
    assign o_field_write_mask = r_field_write_mask;
    assign o_rsp_valid        = r_rsp_valid;
    assign o_rsp_status       = r_rsp_status;
    assign o_rsp_read_data    = r_rsp_read_data;

endmodule
`default_nettype wire

// File: tb/tb_rggen_bit_field_access_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rggen_bit_field_access_driver
// Brief    : Directed scoreboard bench for rggen_bit_field_access_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rggen_bit_field_access_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_address = '0;
    logic [31:0] req_write_data = '0;
    logic [3:0]  req_strobe = '0;
    logic        field_valid;
    logic        field_write;
    logic [7:0]  field_address;
    logic [31:0] field_write_data;
    logic [31:0] field_write_mask;
    logic        field_ready = 1'b0;
    logic        field_error = 1'b0;
    logic [31:0] field_read_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_read_data;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];

    rggen_bit_field_access_driver #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (32),
        .TIMEOUT       (4)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_write        (req_write),
        .i_req_address      (req_address),
        .i_req_write_data   (req_write_data),
        .i_req_strobe       (req_strobe),
        .o_field_valid      (field_valid),
        .o_field_write      (field_write),
        .o_field_address    (field_address),
        .o_field_write_data (field_write_data),
        .o_field_write_mask (field_write_mask),
        .i_field_ready      (field_ready),
        .i_field_error      (field_error),
        .i_field_read_data  (field_read_data),
        .o_rsp_valid        (rsp_valid),
        .i_rsp_ready        (rsp_ready),
        .o_rsp_status       (rsp_status),
        .o_rsp_read_data    (rsp_read_data)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Response monitor: pops one expected response per handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("rsp_status", 32'(rsp_status), 32'(e[33:32]));
                chk("rsp_data", rsp_read_data, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // delay < 0: field never answers
    task automatic txn(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int delay, input bit err, input logic [31:0] rd,
                       input logic [31:0] exp_mask, input int exp_nv,
                       input logic [1:0] est, input logic [31:0] ed, input int rsp_hold);
        int nv;
        exp_q.push_back({est, ed});
        chk("req_ready_idle", 32'(req_ready), 32'(1));
        req_valid = 1'b1; req_write = wr; req_address = a; req_write_data = d; req_strobe = s;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_write_data = '0; req_strobe = '0;
        chk("req_ready_busy", 32'(req_ready), 32'(0));
        chk("field_write", 32'(field_write), 32'(wr));
        chk("field_address", 32'(field_address), 32'(a));
        chk("field_wdata", field_write_data, wr ? d : 32'h0);
        chk("field_mask", field_write_mask, exp_mask);
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            if (!field_valid) break;
            nv++;
            if (c == delay) begin
                field_ready = 1'b1; field_error = err; field_read_data = rd;
            end
            step();
            field_ready = 1'b0; field_error = 1'b0; field_read_data = '0;
        end
        chk("field_valid_cycles", 32'(nv), 32'(exp_nv));
        chk("rsp_valid", 32'(rsp_valid), 32'(1));
        for (int h = 0; h < rsp_hold; h++) begin
            req_valid = 1'b1; req_write = 1'b1; req_strobe = 4'hF;
            step();
            chk("hold_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("hold_req_ready", 32'(req_ready), 32'(0));
            chk("hold_status", 32'(rsp_status), 32'(est));
            chk("hold_data", rsp_read_data, ed);
        end
        req_valid = 1'b0; req_write = 1'b0; req_strobe = '0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_field_valid", 32'(field_valid), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_mask", field_write_mask, 32'h0);
        chk("rst_status", 32'(rsp_status), 32'(0));
        rst_n = 1'b1;
        step();

        // write, ready after two wait cycles
        txn(1'b1, 8'h08, 32'hDEADBEEF, 4'b0101, 2, 1'b0, 32'h0, 32'h00FF00FF, 3, 2'b00, 32'h0, 0);
        // read, immediate ready; write data must not leak onto the field bus
        txn(1'b0, 8'h10, 32'hCAFEF00D, 4'hF, 0, 1'b0, 32'h12345678, 32'h0, 1, 2'b00, 32'h12345678, 0);
        // read, field never answers -> timeout
        txn(1'b0, 8'h20, 32'h0, 4'h0, -1, 1'b0, 32'h0, 32'h0, 4, 2'b11, 32'h0, 0);
        // ready with error on last allowed cycle beats timeout
        txn(1'b0, 8'h24, 32'h0, 4'h0, 3, 1'b1, 32'h0000AAAA, 32'h0, 4, 2'b10, 32'h0000AAAA, 0);
        // zero-strobe write, response back-pressured for five cycles
        txn(1'b1, 8'h30, 32'h01020304, 4'b0000, 1, 1'b0, 32'hFFFFFFFF, 32'h0, 2, 2'b00, 32'h0, 5);
        // write with error; read data from field ignored on writes
        txn(1'b1, 8'hFF, 32'h55AA55AA, 4'b1110, 0, 1'b1, 32'h87654321, 32'hFFFFFF00, 1, 2'b10, 32'h0, 1);

        // reset in the middle of an access
        req_valid = 1'b1; req_write = 1'b1; req_address = 8'h44; req_write_data = 32'h11112222; req_strobe = 4'hF;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_write_data = '0; req_strobe = '0;
        chk("mid_field_valid", 32'(field_valid), 32'(1));
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'(1));
        chk("mid_rst_field_valid", 32'(field_valid), 32'(0));
        chk("mid_rst_mask", field_write_mask, 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        field_ready = 1'b1; field_error = 1'b1; field_read_data = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("post_rst_field_valid", 32'(field_valid), 32'(0));
        end
        field_ready = 1'b0; field_error = 1'b0; field_read_data = '0;
        rsp_ready = 1'b0;
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
